// File: rtl/sd_card_pkg.sv
// Shared definitions for the SD sector arbiter: engine control/status codes,
// arbiter FSM states and sector geometry.
package sd_card_pkg;

  typedef enum logic [7:0] {
    CTRL_NOP   = 8'd0,
    CTRL_READ  = 8'd1,
    CTRL_WRITE = 8'd2
  } sd_ctrl_e;

  localparam logic [7:0] SD_STATUS_DONE = 8'h01;

  localparam int SECTOR_BYTES_DEFAULT = 512;
  localparam int BYTE_CNT_W           = 10;
  localparam int BYTE_IDX_W           = 9;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_XFER,
    ST_COMPLETE
  } arb_state_e;

  // Width of an index into n requesters, never below one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sd_rr_arbiter.sv
// Combinational round-robin grant: first asserted request at or after the
// pointer, wrapping, returned both one-hot and as an index.
module sd_rr_arbiter
  import sd_card_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int IDX_W = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0] o_gnt_idx,
  output logic             o_any
);

  logic [IDX_W-1:0] idx;

  // NOTE: every combinational output gets a default before any branch, so no latches are inferred.
  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    o_any     = 1'b0;
    idx       = '0;
    for (int off = 0; off < N_REQ; off++) begin
      idx = IDX_W'((int'(i_ptr) + off) % N_REQ);
      if (!o_any && i_req[idx]) begin
        o_any      = 1'b1;
        o_gnt[idx] = 1'b1;
        o_gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/sd_sector_arbiter.sv
// Shares one SD block-read engine between N_REQ sector requesters, round-robin.
// Define SD_ARB_TIMEOUT_EN to add a per-transfer watchdog of TIMEOUT_CYC cycles.
module sd_sector_arbiter
  import sd_card_pkg::*;
#(
  parameter int  N_REQ        = 2,
  parameter int  SECTOR_BYTES = SECTOR_BYTES_DEFAULT,
  parameter int  TIMEOUT_CYC  = 2**20,
  localparam int OWN_W        = idx_width(N_REQ)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [N_REQ-1:0]      i_req_valid,
  input  logic [32*N_REQ-1:0]   i_req_sector,
  output logic [N_REQ-1:0]      o_req_ready,
  output logic [N_REQ-1:0]      o_req_done,
  output logic [N_REQ-1:0]      o_req_err,
  output logic [7:0]            o_sd_controlreg,
  output logic [31:0]           o_sd_addr,
  input  logic [7:0]            i_sd_statusreg,
  input  logic                  i_sd_write_status,
  input  logic [7:0]            i_sd_data,
  input  logic                  i_sd_wr_nrd,
  output logic [7:0]            o_byte_data,
  output logic [BYTE_IDX_W-1:0] o_byte_idx,
  output logic                  o_byte_valid,
  output logic [OWN_W-1:0]      o_byte_owner,
  output logic                  o_busy
);

  if (N_REQ < 2 || N_REQ > 4) begin : g_bad_n_req
    $error("sd_sector_arbiter: N_REQ must be 2..4");
  end
  if (SECTOR_BYTES < 1 || SECTOR_BYTES > 512) begin : g_bad_sector_bytes
    $error("sd_sector_arbiter: SECTOR_BYTES must be 1..512");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("sd_sector_arbiter: TIMEOUT_CYC must be positive");
  end

  localparam logic [BYTE_CNT_W-1:0] CNT_FULL = BYTE_CNT_W'(SECTOR_BYTES);
  localparam logic [BYTE_CNT_W-1:0] CNT_SAT  = BYTE_CNT_W'(SECTOR_BYTES + 1);

  arb_state_e            state_q, state_d;
  logic [OWN_W-1:0]      ptr_q, ptr_d;
  logic [OWN_W-1:0]      owner_q, owner_d;
  logic [31:0]           sector_q, sector_d;
  logic [BYTE_CNT_W-1:0] cnt_q, cnt_d;
  logic                  overrun_q, overrun_d;
  logic                  st_err_q, st_err_d;
  logic [N_REQ-1:0]      ready_q, ready_d;
  logic                  byte_valid_q, byte_valid_d;
  logic [7:0]            byte_data_q, byte_data_d;
  logic [BYTE_IDX_W-1:0] byte_idx_q, byte_idx_d;
  logic [OWN_W-1:0]      byte_owner_q, byte_owner_d;

  logic [N_REQ-1:0]      gnt;
  logic [OWN_W-1:0]      gnt_idx;
  logic                  gnt_any;
  logic [31:0]           gnt_sector;
  logic                  active;
  logic                  timeout_hit;
  logic                  xfer_err;

  sd_rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (OWN_W)
  ) u_rr (
    .i_req     (i_req_valid),
    .i_ptr     (ptr_q),
    .o_gnt     (gnt),
    .o_gnt_idx (gnt_idx),
    .o_any     (gnt_any)
  );

  always_comb begin
    gnt_sector = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (gnt_idx == OWN_W'(k)) gnt_sector = i_req_sector[32*k +: 32];
    end
  end

  assign active = (state_q == ST_ISSUE) || (state_q == ST_XFER);

`ifdef SD_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0] wd_q, wd_d;

  // Restarts from zero on every grant because the count only runs while active.
  always_comb begin
    wd_d = '0;
    if (active) wd_d = wd_q + 1'b1;
  end

  assign timeout_hit = active && (wd_q == WD_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) wd_q <= '0;
    else       wd_q <= wd_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    owner_d      = owner_q;
    sector_d     = sector_q;
    cnt_d        = cnt_q;
    overrun_d    = overrun_q;
    st_err_d     = st_err_q;
    ready_d      = '0;
    byte_valid_d = 1'b0;
    byte_data_d  = byte_data_q;
    byte_idx_d   = byte_idx_q;
    byte_owner_d = byte_owner_q;

    // Bytes are counted before a same-cycle status strobe is judged in COMPLETE.
    if (active && i_sd_wr_nrd) begin
      if (cnt_q < CNT_FULL) begin
        byte_valid_d = 1'b1;
        byte_data_d  = i_sd_data;
        byte_idx_d   = cnt_q[BYTE_IDX_W-1:0];
        byte_owner_d = owner_q;
      end else begin
        overrun_d = 1'b1;
      end
      if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (gnt_any) begin
          state_d   = ST_ISSUE;
          owner_d   = gnt_idx;
          sector_d  = gnt_sector;
          ready_d   = gnt;
          ptr_d     = (gnt_idx == OWN_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
          cnt_d     = '0;
          overrun_d = 1'b0;
          st_err_d  = 1'b0;
        end
      end
      ST_ISSUE: begin
        // A status with no data means the engine aborted the read.
        if (i_sd_write_status) begin
          state_d  = ST_COMPLETE;
          st_err_d = 1'b1;
        end else if (i_sd_wr_nrd) begin
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        if (i_sd_write_status) begin
          state_d  = ST_COMPLETE;
          st_err_d = (i_sd_statusreg != SD_STATUS_DONE);
        end
      end
      ST_COMPLETE: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (timeout_hit) begin
      state_d  = ST_COMPLETE;
      st_err_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      owner_q      <= '0;
      sector_q     <= '0;
      cnt_q        <= '0;
      overrun_q    <= 1'b0;
      st_err_q     <= 1'b0;
      ready_q      <= '0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= '0;
      byte_idx_q   <= '0;
      byte_owner_q <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      owner_q      <= owner_d;
      sector_q     <= sector_d;
      cnt_q        <= cnt_d;
      overrun_q    <= overrun_d;
      st_err_q     <= st_err_d;
      ready_q      <= ready_d;
      byte_valid_q <= byte_valid_d;
      byte_data_q  <= byte_data_d;
      byte_idx_q   <= byte_idx_d;
      byte_owner_q <= byte_owner_d;
    end
  end

  assign xfer_err = st_err_q || overrun_q || (cnt_q != CNT_FULL);

  always_comb begin
    o_req_done = '0;
    if (state_q == ST_COMPLETE) o_req_done[owner_q] = 1'b1;
  end

  assign o_req_err       = xfer_err ? o_req_done : '0;
  assign o_req_ready     = ready_q;
  assign o_sd_controlreg = (state_q == ST_ISSUE) ? CTRL_READ : CTRL_NOP;
  assign o_sd_addr       = sector_q;
  assign o_busy          = (state_q != ST_IDLE);
  assign o_byte_data     = byte_data_q;
  assign o_byte_idx      = byte_idx_q;
  assign o_byte_valid    = byte_valid_q;
  assign o_byte_owner    = byte_owner_q;

endmodule

// File: tb/tb_sd_sector_arbiter.sv
// Randomised self-checking bench for sd_sector_arbiter against a transaction-level
// reference: round-robin grant order, expected byte stream and done/err outcome.
module tb_sd_sector_arbiter;

  localparam int N_REQ        = 2;
  localparam int SECTOR_BYTES = 512;
  localparam int TIMEOUT_CYC  = 100;
  localparam int OW           = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef logic [16+OW:0] byte_rec_t;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [N_REQ-1:0]      req_valid;
  logic [32*N_REQ-1:0]   req_sector;
  logic [N_REQ-1:0]      o_req_ready, o_req_done, o_req_err;
  logic [7:0]            o_sd_controlreg;
  logic [31:0]           o_sd_addr;
  logic [7:0]            sd_statusreg;
  logic                  sd_write_status;
  logic [7:0]            sd_data;
  logic                  sd_wr_nrd;
  logic [7:0]            o_byte_data;
  logic [8:0]            o_byte_idx;
  logic                  o_byte_valid;
  logic [OW-1:0]         o_byte_owner;
  logic                  o_busy;

  int errors = 0;
  int checks = 0;
  int ptr_m  = 0;
  byte_rec_t got_q[$];
  byte_rec_t exp_q[$];

  always #5 clk = ~clk;

  sd_sector_arbiter #(
    .N_REQ        (N_REQ),
    .SECTOR_BYTES (SECTOR_BYTES),
    .TIMEOUT_CYC  (TIMEOUT_CYC)
  ) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_req_valid       (req_valid),
    .i_req_sector      (req_sector),
    .o_req_ready       (o_req_ready),
    .o_req_done        (o_req_done),
    .o_req_err         (o_req_err),
    .o_sd_controlreg   (o_sd_controlreg),
    .o_sd_addr         (o_sd_addr),
    .i_sd_statusreg    (sd_statusreg),
    .i_sd_write_status (sd_write_status),
    .i_sd_data         (sd_data),
    .i_sd_wr_nrd       (sd_wr_nrd),
    .o_byte_data       (o_byte_data),
    .o_byte_idx        (o_byte_idx),
    .o_byte_valid      (o_byte_valid),
    .o_byte_owner      (o_byte_owner),
    .o_busy            (o_busy)
  );

  always @(negedge clk) begin
    if (o_byte_valid === 1'b1) got_q.push_back({o_byte_data, o_byte_idx, o_byte_owner});
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not reach its summary");
    $fatal(1, "bench time limit exceeded");
  end

  // Round-robin rule: lowest offset from the pointer, wrapping, among active requests.
  function automatic int model_grant(input logic [N_REQ-1:0] r);
    int g = -1;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (r[(ptr_m + k) % N_REQ]) g = (ptr_m + k) % N_REQ;
    end
    return g;
  endfunction

  task automatic engine_idle();
    sd_wr_nrd       = 1'b0;
    sd_write_status = 1'b0;
    sd_data         = '0;
    sd_statusreg    = '0;
  endtask

  task automatic check_all_zero(input string name);
    checks++; if (o_req_ready !== '0) begin errors++; $display("FAIL %s ready: got %b want 0", name, o_req_ready); end
    checks++; if (o_req_done !== '0) begin errors++; $display("FAIL %s done: got %b want 0", name, o_req_done); end
    checks++; if (o_req_err !== '0) begin errors++; $display("FAIL %s err: got %b want 0", name, o_req_err); end
    checks++; if (o_sd_controlreg !== 8'd0) begin errors++; $display("FAIL %s controlreg: got %0d want 0", name, o_sd_controlreg); end
    checks++; if (o_sd_addr !== 32'd0) begin errors++; $display("FAIL %s addr: got %h want 0", name, o_sd_addr); end
    checks++; if (o_byte_valid !== 1'b0) begin errors++; $display("FAIL %s byte_valid: got %b want 0", name, o_byte_valid); end
    checks++; if (o_byte_data !== 8'd0 || o_byte_idx !== 9'd0 || o_byte_owner !== '0) begin
      errors++; $display("FAIL %s byte_fields: got data=%h idx=%0d owner=%0d want 0", name, o_byte_data, o_byte_idx, o_byte_owner);
    end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL %s busy: got %b want 0", name, o_busy); end
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; engine_idle();
    repeat (2) @(negedge clk);
    rst = 1'b0; ptr_m = 0;
    @(negedge clk);
  endtask

  task automatic request_grant(input logic [N_REQ-1:0] reqs, input logic [31:0] sec0, input bit fix0,
                               input string name, output int g);
    logic [31:0]      sec [N_REQ];
    logic [N_REQ-1:0] exp_oh;
    int               waited;
    g = model_grant(reqs);
    for (int k = 0; k < N_REQ; k++) begin
      sec[k] = $urandom;
      if (k == 0 && fix0) sec[k] = sec0;
      req_sector[32*k +: 32] = sec[k];
    end
    exp_oh = '0; exp_oh[g] = 1'b1;
    got_q.delete(); exp_q.delete();
    req_valid = reqs;
    waited = 0;
    do begin @(negedge clk); waited++; end while (o_req_ready === '0 && waited < 8);
    req_valid = '0;
    checks++; if (o_req_ready !== exp_oh) begin errors++; $display("FAIL %s ready: got %b want %b", name, o_req_ready, exp_oh); end
    checks++; if (o_sd_controlreg !== 8'd1) begin errors++; $display("FAIL %s issue_ctrl: got %0d want 1", name, o_sd_controlreg); end
    checks++; if (o_sd_addr !== sec[g]) begin errors++; $display("FAIL %s addr: got %h want %h", name, o_sd_addr, sec[g]); end
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL %s busy: got %b want 1", name, o_busy); end
    ptr_m = (g + 1) % N_REQ;
  endtask

  task automatic send_bytes(input int n, input int g, input bit coincide, input logic [7:0] status, input string name);
    int gap;
    for (int i = 0; i < n; i++) begin
      gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      if (gap > 0) begin engine_idle(); repeat (gap) @(negedge clk); end
      sd_wr_nrd = 1'b1;
      sd_data   = 8'($urandom);
      if (coincide && i == n - 1) begin sd_write_status = 1'b1; sd_statusreg = status; end
      if (i < SECTOR_BYTES) exp_q.push_back({sd_data, 9'(i), OW'(g)});
      @(negedge clk);
      if (i == 0) begin
        checks++; if (o_sd_controlreg !== 8'd0) begin errors++; $display("FAIL %s ctrl_drop: got %0d want 0", name, o_sd_controlreg); end
      end
    end
    engine_idle();
  endtask

  task automatic send_status(input logic [7:0] status);
    sd_write_status = 1'b1; sd_statusreg = status;
    @(negedge clk);
    engine_idle();
  endtask

  task automatic wait_done(input int g, input bit exp_err, input string name);
    logic [N_REQ-1:0] exp_oh;
    int               waited = 0;
    exp_oh = '0; exp_oh[g] = 1'b1;
    while (o_req_done === '0 && waited < 8) begin @(negedge clk); waited++; end
    checks++; if (o_req_done !== exp_oh) begin errors++; $display("FAIL %s done: got %b want %b", name, o_req_done, exp_oh); end
    checks++; if (o_req_err !== (exp_err ? exp_oh : '0)) begin
      errors++; $display("FAIL %s err: got %b want %b", name, o_req_err, exp_err ? exp_oh : '0);
    end
    checks++; if (o_sd_controlreg !== 8'd0) begin errors++; $display("FAIL %s done_ctrl: got %0d want 0", name, o_sd_controlreg); end
    @(negedge clk);
    checks++; if (o_req_done !== '0 || o_busy !== 1'b0) begin
      errors++; $display("FAIL %s after_done: got done=%b busy=%b want 0/0", name, o_req_done, o_busy);
    end
  endtask

  task automatic compare_bytes(input string name);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL %s byte_count: got %0d want %0d", name, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL %s byte[%0d]: got data=%h idx=%0d owner=%0d want data=%h idx=%0d owner=%0d", name, i,
                 got_q[i][16+OW:9+OW], got_q[i][8+OW:OW], got_q[i][OW-1:0],
                 exp_q[i][16+OW:9+OW], exp_q[i][8+OW:OW], exp_q[i][OW-1:0]);
        break;
      end
    end
  endtask

  task automatic run_xfer(input logic [N_REQ-1:0] reqs, input int n, input logic [7:0] status, input bit coincide,
                          input string name, input logic [31:0] sec0 = '0, input bit fix0 = 1'b0);
    int g;
    bit same = coincide && (n > 0);
    request_grant(reqs, sec0, fix0, name, g);
    engine_idle();
    repeat ($urandom_range(0, 3)) @(negedge clk);
    send_bytes(n, g, same, status, name);
    if (!same) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send_status(status);
    end
    wait_done(g, (status != 8'h01) || (n != SECTOR_BYTES), name);
    compare_bytes(name);
  endtask

  task automatic test_reset();
    do_reset();
    check_all_zero("reset");
  endtask

  task automatic test_single();
    run_xfer(2'b01, SECTOR_BYTES, 8'h01, 1'b0, "single", 32'h10, 1'b1);
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < 3; i++) run_xfer('1, SECTOR_BYTES, 8'h01, 1'($urandom_range(0, 1)), "round_robin");
  endtask

  task automatic test_short_sector();
    run_xfer(N_REQ'($urandom_range(1, (1 << N_REQ) - 1)), SECTOR_BYTES - 1, 8'h01, 1'b0, "short_sector");
  endtask

  task automatic test_issue_error();
    run_xfer(N_REQ'($urandom_range(1, (1 << N_REQ) - 1)), 0, 8'h03, 1'b0, "issue_error");
  endtask

  task automatic test_overrun();
    run_xfer(N_REQ'($urandom_range(1, (1 << N_REQ) - 1)), SECTOR_BYTES + 2, 8'h01, 1'b1, "overrun");
  endtask

  task automatic test_random();
    int          n_tab [4] = '{SECTOR_BYTES - 1, SECTOR_BYTES, SECTOR_BYTES, SECTOR_BYTES + 1};
    logic [7:0]  s_tab [3] = '{8'h01, 8'h01, 8'h05};
    for (int i = 0; i < 4; i++) begin
      run_xfer(N_REQ'($urandom_range(1, (1 << N_REQ) - 1)), n_tab[$urandom_range(0, 3)],
               s_tab[$urandom_range(0, 2)], 1'($urandom_range(0, 1)), "random");
    end
  endtask

  task automatic test_reset_mid();
    int g;
    request_grant(N_REQ'($urandom_range(1, (1 << N_REQ) - 1)), '0, 1'b0, "reset_mid", g);
    for (int i = 0; i < 200; i++) begin
      sd_wr_nrd = 1'b1; sd_data = 8'($urandom);
      @(negedge clk);
    end
    sd_data = 8'hA5; rst = 1'b1;
    @(negedge clk);
    check_all_zero("reset_mid");
    rst = 1'b0; ptr_m = 0;
    for (int i = 0; i < 6; i++) begin
      sd_wr_nrd = 1'b1; sd_data = 8'($urandom);
      if (i == 5) begin sd_write_status = 1'b1; sd_statusreg = 8'h01; end
      @(negedge clk);
      checks++;
      if (o_byte_valid !== 1'b0 || o_req_done !== '0 || o_busy !== 1'b0) begin
        errors++; $display("FAIL reset_mid stray_strobe: got valid=%b done=%b busy=%b want 0/0/0", o_byte_valid, o_req_done, o_busy);
      end
    end
    engine_idle();
    @(negedge clk);
    run_xfer(N_REQ'($urandom_range(1, (1 << N_REQ) - 1)), SECTOR_BYTES, 8'h01, 1'b0, "after_reset");
  endtask

  task automatic test_silent_engine();
    int g;
    request_grant(2'b01, '0, 1'b0, "silent", g);
    engine_idle();
`ifdef SD_ARB_TIMEOUT_EN
    begin
      int               first = -1;
      logic [N_REQ-1:0] err_v = '0;
      for (int c = 1; c <= TIMEOUT_CYC + 5; c++) begin
        @(negedge clk);
        if (first < 0 && o_req_done !== '0) begin first = c; err_v = o_req_err; end
      end
      checks++; if (first != TIMEOUT_CYC) begin errors++; $display("FAIL silent timeout_cycle: got %0d want %0d", first, TIMEOUT_CYC); end
      checks++; if (err_v !== N_REQ'(1)) begin errors++; $display("FAIL silent timeout_err: got %b want %b", err_v, N_REQ'(1)); end
    end
`else
    begin
      int dones = 0;
      for (int c = 0; c < 150; c++) begin
        @(negedge clk);
        if (o_req_done !== '0) dones++;
      end
      checks++; if (dones != 0) begin errors++; $display("FAIL silent no_done: got %0d done pulses want 0", dones); end
      checks++; if (o_busy !== 1'b1 || o_sd_controlreg !== 8'd1) begin
        errors++; $display("FAIL silent still_waiting: got busy=%b ctrl=%0d want 1/1", o_busy, o_sd_controlreg);
      end
      send_status(8'h03);
      wait_done(g, 1'b1, "silent");
    end
`endif
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_sector = '0; engine_idle();
    test_reset();
    test_single();
    test_round_robin();
    test_short_sector();
    test_issue_error();
    test_overrun();
    test_random();
    test_reset_mid();
    test_silent_engine();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
